// File: rtl/morph_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : morph_mode_ctrl
// Description : Frame-synchronous mode controller for the two-stage binary
//               morphology pipeline. It accepts mode requests through a
//               valid/ready handshake, applies them only at a frame boundary,
//               blanks the output while the line buffers refill, and checks
//               line length and line count of the incoming sync stream.
// Ports       : clk, rst            - pixel clock, synchronous active-high reset
//               de_in, h_sync_in,
//               v_sync_in           - incoming stream timing (de_in monitor only)
//               mode_req[2:0],
//               mode_req_valid,
//               mode_req_ready      - mode request handshake
//               stage1_sel[1:0],
//               stage2_sel[1:0]     - 00 bypass, 01 erosion, 10 dilation
//               mode_active[2:0]    - mode currently applied
//               blank_out           - force pipeline output to black
//               mode_done           - pulse when blanking ends after a switch
//               mode_err            - pulse when an illegal mode is accepted
//               geom_err            - sticky line-length mismatch flag
//               lines_per_frame     - h_sync rises counted in previous frame
// Revision    : 1.0 - initial release
// ============================================================================
module morph_mode_ctrl #(
  parameter int H_SIZE       = 1664,
  parameter int FLUSH_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [2:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  output logic [1:0]  stage1_sel,
  output logic [1:0]  stage2_sel,
  output logic [2:0]  mode_active,
  output logic        blank_out,
  output logic        mode_done,
  output logic        mode_err,
  output logic        geom_err,
  output logic [11:0] lines_per_frame
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [3:0]  c_flush_init = 4'(FLUSH_FRAMES);
  localparam logic [15:0] c_h_size     = 16'(H_SIZE);
  localparam logic [2:0]  c_mode_max   = 3'd4;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vs_q;
  logic        r_hs_q;
  logic        w_vs_rise;
  logic        w_hs_rise;

  logic [2:0]  r_pend_mode;
  logic [3:0]  r_flush_cnt;
  logic [2:0]  r_mode_active;
  logic        r_mode_done;
  logic        r_mode_err;

  logic        r_geom_err;
  logic        r_hs_seen;
  logic [15:0] r_line_clk;
  logic [11:0] r_line_cnt;
  logic [11:0] r_lines_per_frame;
  logic [11:0] w_line_cnt_inc;

  logic        w_ready;
  logic        w_blank;
  logic        w_legal_req;
  logic        w_store;
  logic        w_start_flush;
  logic [2:0]  w_new_mode;
  logic        w_dec_flush;
  logic        w_done;
  logic        w_err;

  logic        w_unused;

  // de_in is carried for stream-monitoring symmetry only.
  assign w_unused    = de_in;

  assign w_vs_rise   = v_sync_in & ~r_vs_q;
  assign w_hs_rise   = h_sync_in & ~r_hs_q;
  assign w_legal_req = (mode_req <= c_mode_max);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = 1'b0;
    w_blank       = 1'b1;
    w_store       = 1'b0;
    w_start_flush = 1'b0;
    w_new_mode    = 3'd0;
    w_dec_flush   = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt   = ST_FLUSH;
          w_start_flush = 1'b1;
          w_new_mode    = 3'd0;
        end
      end
      ST_RUN: begin
        // A vs_rise here is ignored, so a request accepted on a frame
        // boundary waits in PENDING for the following boundary.
        w_ready = 1'b1;
        w_blank = 1'b0;
        if (mode_req_valid) begin
          if (w_legal_req) begin
            w_state_nxt = ST_PENDING;
            w_store     = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        // The old mode keeps running unblanked until the boundary.
        w_blank = 1'b0;
        if (w_vs_rise) begin
          w_state_nxt   = ST_FLUSH;
          w_start_flush = 1'b1;
          w_new_mode    = r_pend_mode;
        end
      end
      ST_FLUSH: begin
        if (w_vs_rise) begin
          w_dec_flush = (r_flush_cnt != 4'd0);
          // Count of 1 (or 0 from an out-of-range parameter) ends blanking.
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Mode datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q        <= 1'b0;
      r_hs_q        <= 1'b0;
      r_pend_mode   <= 3'd0;
      r_flush_cnt   <= 4'd0;
      r_mode_active <= 3'd0;
      r_mode_done   <= 1'b0;
      r_mode_err    <= 1'b0;
    end else begin
      r_vs_q      <= v_sync_in;
      r_hs_q      <= h_sync_in;
      r_mode_done <= w_done;
      r_mode_err  <= w_err;
      if (w_store) begin
        r_pend_mode <= mode_req;
      end
      if (w_start_flush) begin
        r_flush_cnt   <= c_flush_init;
        r_mode_active <= w_new_mode;
      end else if (w_dec_flush) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line geometry and line counting
  // --------------------------------------------------------------------------
  assign w_line_cnt_inc = (w_hs_rise && (r_line_cnt != 12'hFFF)) ?
                          (r_line_cnt + 12'd1) : r_line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_geom_err        <= 1'b0;
      r_hs_seen         <= 1'b0;
      r_line_clk        <= 16'd0;
      r_line_cnt        <= 12'd0;
      r_lines_per_frame <= 12'd0;
    end else begin
      // line_clk reads 1 on the cycle after hs_rise, so a correct line
      // shows exactly H_SIZE on the cycle of the next hs_rise.
      if (w_hs_rise) begin
        r_line_clk <= 16'd1;
        r_hs_seen  <= 1'b1;
        if (r_hs_seen && (r_line_clk != c_h_size)) begin
          r_geom_err <= 1'b1;
        end
      end else if (r_line_clk != 16'hFFFF) begin
        r_line_clk <= r_line_clk + 16'd1;
      end

      // An hs_rise coincident with vs_rise belongs to the closing frame.
      if (w_vs_rise) begin
        r_lines_per_frame <= w_line_cnt_inc;
        r_line_cnt        <= 12'd0;
      end else begin
        r_line_cnt <= w_line_cnt_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage select decode
  // --------------------------------------------------------------------------
  always_comb begin
    stage1_sel = 2'b00;
    stage2_sel = 2'b00;
    case (r_mode_active)
      3'd1: begin stage1_sel = 2'b01; stage2_sel = 2'b00; end
      3'd2: begin stage1_sel = 2'b10; stage2_sel = 2'b00; end
      3'd3: begin stage1_sel = 2'b01; stage2_sel = 2'b10; end
      3'd4: begin stage1_sel = 2'b10; stage2_sel = 2'b01; end
      default: begin stage1_sel = 2'b00; stage2_sel = 2'b00; end
    endcase
  end

  assign mode_req_ready  = w_ready;
  assign blank_out       = w_blank;
  assign mode_active     = r_mode_active;
  assign mode_done       = r_mode_done;
  assign mode_err        = r_mode_err;
  assign geom_err        = r_geom_err;
  assign lines_per_frame = r_lines_per_frame;

endmodule
`default_nettype wire

// File: tb/tb_morph_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_morph_mode_ctrl
// Description : Self-checking bench for morph_mode_ctrl. A free-running sync
//               generator produces 1664-clock lines; the main sequence drives
//               mode requests and resets, pushes expected output records to a
//               scoreboard queue and compares them after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morph_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0;
  logic        h_sync_in = 1'b0;
  logic        v_sync_in = 1'b0;
  logic [2:0]  mode_req = 3'd0;
  logic        mode_req_valid = 1'b0;
  logic        mode_req_ready;
  logic [1:0]  stage1_sel;
  logic [1:0]  stage2_sel;
  logic [2:0]  mode_active;
  logic        blank_out;
  logic        mode_done;
  logic        mode_err;
  logic        geom_err;
  logic [11:0] lines_per_frame;

  always #5 clk = ~clk;

  morph_mode_ctrl #(
    .H_SIZE       (1664),
    .FLUSH_FRAMES (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .de_in           (de_in),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .mode_req        (mode_req),
    .mode_req_valid  (mode_req_valid),
    .mode_req_ready  (mode_req_ready),
    .stage1_sel      (stage1_sel),
    .stage2_sel      (stage2_sel),
    .mode_active     (mode_active),
    .blank_out       (blank_out),
    .mode_done       (mode_done),
    .mode_err        (mode_err),
    .geom_err        (geom_err),
    .lines_per_frame (lines_per_frame)
  );

  // --------------------------------------------------------------------------
  // Sync generator: line length 1664 (1663 once when tb_short is set),
  // h_sync high for pixels 0..39, v_sync high in line 0 pixels 10..99.
  // --------------------------------------------------------------------------
  bit   gen_en   = 1'b0;
  bit   tb_short = 1'b0;
  int   tb_nlines = 4;
  int   gp = 0;
  int   gline = 0;
  int   glen = 1664;
  event ev_vs;
  event ev_hs;

  always @(negedge clk) begin
    if (gen_en) begin
      h_sync_in = (gp < 40);
      v_sync_in = (gline == 0) && (gp >= 10) && (gp < 100);
      de_in     = (gp >= 200) && (gp < 1480);
      if (gp == 0) -> ev_hs;
      if ((gline == 0) && (gp == 10)) -> ev_vs;
      if (gp == glen - 1) begin
        gp       = 0;
        glen     = tb_short ? 1663 : 1664;
        tb_short = 1'b0;
        gline    = (gline + 1 >= tb_nlines) ? 0 : gline + 1;
      end else begin
        gp = gp + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        ready;
    logic        blank;
    logic [2:0]  mode;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        done;
    logic        err;
    logic        geom;
    int          lpf;     // -1: not checked
  } exp_t;

  typedef struct {
    logic [2:0] req;
    bit         legal;
    logic [1:0] s1;
    logic [1:0] s2;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void expect_out(string name, logic rdy, logic blk,
                                     logic [2:0] md, logic [1:0] s1,
                                     logic [1:0] s2, logic dn, logic er,
                                     logic ge, int lpf);
    exp_t e;
    e.name = name; e.ready = rdy; e.blank = blk; e.mode = md;
    e.s1 = s1; e.s2 = s2; e.done = dn; e.err = er; e.geom = ge; e.lpf = lpf;
    sb_q.push_back(e);
  endfunction

  function automatic void cmp(string tag, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endfunction

  function automatic void sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp({e.name, ".ready"}, 16'(mode_req_ready), 16'(e.ready));
      cmp({e.name, ".blank"}, 16'(blank_out),      16'(e.blank));
      cmp({e.name, ".mode"},  16'(mode_active),    16'(e.mode));
      cmp({e.name, ".s1"},    16'(stage1_sel),     16'(e.s1));
      cmp({e.name, ".s2"},    16'(stage2_sel),     16'(e.s2));
      cmp({e.name, ".done"},  16'(mode_done),      16'(e.done));
      cmp({e.name, ".err"},   16'(mode_err),       16'(e.err));
      cmp({e.name, ".geom"},  16'(geom_err),       16'(e.geom));
      if (e.lpf >= 0) cmp({e.name, ".lpf"}, 16'(lines_per_frame), 16'(e.lpf));
    end
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which the DUT sees vs_rise.
  task automatic after_vs();
    @(ev_vs);
    @(posedge clk);
    #1;
  endtask

  task automatic after_hs();
    @(ev_hs);
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle request; returns just after the accepting edge.
  task automatic drive_req(logic [2:0] m);
    mode_req       = m;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1;
    mode_req_valid = 1'b0;
  endtask

  // Watchdog
  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    vec_t       vecs[7];
    logic [2:0] cur_mode;
    logic [1:0] cur_s1;
    logic [1:0] cur_s2;

    vecs[0] = '{req: 3'd3, legal: 1'b1, s1: 2'b01, s2: 2'b10};
    vecs[1] = '{req: 3'd6, legal: 1'b0, s1: 2'b00, s2: 2'b00};
    vecs[2] = '{req: 3'd1, legal: 1'b1, s1: 2'b01, s2: 2'b00};
    vecs[3] = '{req: 3'd2, legal: 1'b1, s1: 2'b10, s2: 2'b00};
    vecs[4] = '{req: 3'd7, legal: 1'b0, s1: 2'b00, s2: 2'b00};
    vecs[5] = '{req: 3'd4, legal: 1'b1, s1: 2'b10, s2: 2'b01};
    vecs[6] = '{req: 3'd0, legal: 1'b1, s1: 2'b00, s2: 2'b00};

    // Reset and start-up with 4-line frames
    rst = 1'b1;
    cyc(3);
    expect_out("reset", 0, 1, 3'd0, 2'b00, 2'b00, 0, 0, 0, 0);
    sb_check();
    rst    = 1'b0;
    gen_en = 1'b1;
    after_hs();
    expect_out("idle", 0, 1, 3'd0, 2'b00, 2'b00, 0, 0, 0, 0);
    sb_check();
    after_vs();
    expect_out("flush_f1", 0, 1, 3'd0, 2'b00, 2'b00, 0, 0, 0, 1);
    sb_check();
    after_vs();
    expect_out("run_f2", 1, 0, 3'd0, 2'b00, 2'b00, 1, 0, 0, 4);
    sb_check();
    cyc(1);
    expect_out("run_done_clr", 1, 0, 3'd0, 2'b00, 2'b00, 0, 0, 0, 4);
    sb_check();
    after_vs();
    expect_out("run_f3", 1, 0, 3'd0, 2'b00, 2'b00, 0, 0, 0, 4);
    sb_check();

    // Shorter 1-line frames for the remaining tests
    tb_nlines = 1;
    cur_mode  = 3'd0;
    cur_s1    = 2'b00;
    cur_s2    = 2'b00;

    for (int i = 0; i < 7; i++) begin
      cyc(300);
      drive_req(vecs[i].req);
      if (vecs[i].legal) begin
        expect_out("accept", 0, 0, cur_mode, cur_s1, cur_s2, 0, 0, 0, -1);
        sb_check();
        cyc(1);
        expect_out("pend_hold", 0, 0, cur_mode, cur_s1, cur_s2, 0, 0, 0, -1);
        sb_check();
        after_vs();
        cur_mode = vecs[i].req;
        cur_s1   = vecs[i].s1;
        cur_s2   = vecs[i].s2;
        expect_out("apply", 0, 1, cur_mode, cur_s1, cur_s2, 0, 0, 0, 1);
        sb_check();
        after_vs();
        expect_out("mode_done", 1, 0, cur_mode, cur_s1, cur_s2, 1, 0, 0, 1);
        sb_check();
        cyc(1);
        expect_out("done_clr", 1, 0, cur_mode, cur_s1, cur_s2, 0, 0, 0, -1);
        sb_check();
      end else begin
        expect_out("illegal", 1, 0, cur_mode, cur_s1, cur_s2, 0, 1, 0, -1);
        sb_check();
        cyc(1);
        expect_out("err_clr", 1, 0, cur_mode, cur_s1, cur_s2, 0, 0, 0, -1);
        sb_check();
      end
    end

    // Request accepted on the same cycle as vs_rise
    @(ev_vs);
    mode_req       = 3'd4;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1;
    mode_req_valid = 1'b0;
    expect_out("sc_accept", 0, 0, 3'd0, 2'b00, 2'b00, 0, 0, 0, -1);
    sb_check();
    cyc(5);
    expect_out("sc_pending", 0, 0, 3'd0, 2'b00, 2'b00, 0, 0, 0, -1);
    sb_check();
    after_vs();
    expect_out("sc_apply", 0, 1, 3'd4, 2'b10, 2'b01, 0, 0, 0, -1);
    sb_check();
    after_vs();
    expect_out("sc_done", 1, 0, 3'd4, 2'b10, 2'b01, 1, 0, 0, -1);
    sb_check();

    // One 1663-clock line
    @(ev_hs);
    tb_short = 1'b1;
    after_hs();
    expect_out("geom_before", 1, 0, 3'd4, 2'b10, 2'b01, 0, 0, 0, -1);
    sb_check();
    after_hs();
    expect_out("geom_set", 1, 0, 3'd4, 2'b10, 2'b01, 0, 0, 1, -1);
    sb_check();
    after_vs();
    after_vs();
    expect_out("geom_sticky", 1, 0, 3'd4, 2'b10, 2'b01, 0, 0, 1, 1);
    sb_check();

    // Reset while PENDING with mode 2
    cyc(300);
    drive_req(3'd2);
    expect_out("rst_pend", 0, 0, 3'd4, 2'b10, 2'b01, 0, 0, 1, -1);
    sb_check();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("rst_mid", 0, 1, 3'd0, 2'b00, 2'b00, 0, 0, 0, 0);
    sb_check();
    after_vs();
    expect_out("rst_flush", 0, 1, 3'd0, 2'b00, 2'b00, 0, 0, 0, -1);
    sb_check();
    after_vs();
    expect_out("rst_run", 1, 0, 3'd0, 2'b00, 2'b00, 1, 0, 0, 1);
    sb_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
